// File: rtl/axi_port_arbiter.sv
// Two-master round-robin arbiter onto one AXI peripheral port, with a busy watchdog that turns a hung slave into a fault.
// Latency: zero cycles in IDLE (request passes straight through). Backpressure: rN_wait holds a requester while the port is busy or owned by the other master.
module axi_port_arbiter #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      r0_rd_en,
    input  logic                      r0_wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] r0_addr,
    input  logic [31:0]               r0_wr_data,
    input  logic [3:0]                r0_wr_strobe,
    output logic [31:0]               r0_rd_data,
    output logic                      r0_wait,
    output logic                      r0_err,
    input  logic                      r1_rd_en,
    input  logic                      r1_wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] r1_addr,
    input  logic [31:0]               r1_wr_data,
    input  logic [3:0]                r1_wr_strobe,
    output logic [31:0]               r1_rd_data,
    output logic                      r1_wait,
    output logic                      r1_err,
    output logic                      axi_rd_en,
    output logic                      axi_wr_en,
    output logic [AXI_ADDR_WIDTH-1:0] axi_addr,
    output logic [31:0]               axi_wr_data,
    output logic [3:0]                axi_wr_strobe,
    input  logic [31:0]               axi_rd_data,
    input  logic                      axi_busy,
    input  logic                      axi_access_fault
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMO_ONE = CW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            gnt_q, gnt_d;
    logic            last_grant_q, last_grant_d;
    logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic [1:0]      req;
    logic [1:0]      ill;
    logic [1:0]      vld;
    logic            g;
    logic            drive;
    logic            complete;
    logic            tmo_hit;
    logic            out_en;
    logic [1:0]      wait_v;
    logic [1:0]      err_v;

    assign req = {r1_rd_en | r1_wr_en, r0_rd_en | r0_wr_en};
    assign ill = {r1_rd_en & r1_wr_en, r0_rd_en & r0_wr_en};
    assign vld = req & ~ill;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        tmo_cnt_d    = tmo_cnt_q;
        g            = gnt_q;
        drive        = 1'b0;
        complete     = 1'b0;
        tmo_hit      = 1'b0;
        wait_v       = 2'b00;
        err_v        = 2'b00;

        if (state_q == IDLE) begin
            if (vld[0] | vld[1]) begin
                // On a tie the requester not served last wins.
                g     = (vld[0] & vld[1]) ? ~last_grant_q : vld[1];
                drive = 1'b1;
                if (axi_busy) begin
                    state_d   = BUSY;
                    gnt_d     = g;
                    tmo_cnt_d = TMO_ONE;
                end else begin
                    complete     = 1'b1;
                    last_grant_d = g;
                end
            end
        end else begin
            if (!req[gnt_q]) begin
                state_d   = IDLE;
                tmo_cnt_d = '0;
            end else if (!axi_busy) begin
                drive        = 1'b1;
                complete     = 1'b1;
                last_grant_d = gnt_q;
                state_d      = IDLE;
                tmo_cnt_d    = '0;
            end else if (tmo_cnt_q != TMO_MAX) begin
                drive     = 1'b1;
                tmo_cnt_d = tmo_cnt_q + TMO_ONE;
            end else begin
                tmo_hit      = 1'b1;
                last_grant_d = gnt_q;
                state_d      = IDLE;
                tmo_cnt_d    = '0;
            end
        end

        for (int n = 0; n < 2; n++) begin
            if ((drive | tmo_hit) && (g == 1'(n))) begin
                wait_v[n] = drive & ~complete;
                err_v[n]  = complete ? axi_access_fault : tmo_hit;
            end else begin
                wait_v[n] = vld[n];
                err_v[n]  = ill[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    // Every output is squashed while reset is asserted, independent of state.
    assign out_en        = rst_n & drive;
    assign axi_rd_en     = out_en & (g ? r1_rd_en : r0_rd_en);
    assign axi_wr_en     = out_en & (g ? r1_wr_en : r0_wr_en);
    assign axi_addr      = out_en ? (g ? r1_addr : r0_addr) : '0;
    assign axi_wr_data   = out_en ? (g ? r1_wr_data : r0_wr_data) : '0;
    assign axi_wr_strobe = out_en ? (g ? r1_wr_strobe : r0_wr_strobe) : '0;

    assign r0_rd_data = (rst_n & complete & ~g) ? axi_rd_data : '0;
    assign r1_rd_data = (rst_n & complete & g) ? axi_rd_data : '0;
    assign r0_wait    = rst_n & wait_v[0];
    assign r1_wait    = rst_n & wait_v[1];
    assign r0_err     = rst_n & err_v[0];
    assign r1_err     = rst_n & err_v[1];

endmodule

// File: tb/tb_axi_port_arbiter.sv
// Bench for axi_port_arbiter: directed literal cases followed by random traffic, all checked per cycle against a queue-free owner/round-robin model.
module tb_axi_port_arbiter;

    localparam int AW = 32;
    localparam int T  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           rd_en [2];
    logic           wr_en [2];
    logic [AW-1:0]  addr  [2];
    logic [31:0]    wdat  [2];
    logic [3:0]     strb  [2];
    logic [31:0]    rdat_o[2];
    logic           wait_o[2];
    logic           err_o [2];
    logic           axi_rd_en, axi_wr_en;
    logic [AW-1:0]  axi_addr;
    logic [31:0]    axi_wr_data;
    logic [3:0]     axi_wr_strobe;
    logic [31:0]    axi_rd_data;
    logic           axi_busy, axi_access_fault;

    axi_port_arbiter #(.AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_rd_en(rd_en[0]), .r0_wr_en(wr_en[0]), .r0_addr(addr[0]),
        .r0_wr_data(wdat[0]), .r0_wr_strobe(strb[0]),
        .r0_rd_data(rdat_o[0]), .r0_wait(wait_o[0]), .r0_err(err_o[0]),
        .r1_rd_en(rd_en[1]), .r1_wr_en(wr_en[1]), .r1_addr(addr[1]),
        .r1_wr_data(wdat[1]), .r1_wr_strobe(strb[1]),
        .r1_rd_data(rdat_o[1]), .r1_wait(wait_o[1]), .r1_err(err_o[1]),
        .axi_rd_en(axi_rd_en), .axi_wr_en(axi_wr_en), .axi_addr(axi_addr),
        .axi_wr_data(axi_wr_data), .axi_wr_strobe(axi_wr_strobe),
        .axi_rd_data(axi_rd_data), .axi_busy(axi_busy),
        .axi_access_fault(axi_access_fault)
    );

    // Model: who owns the port (-1 = nobody), who was served last, busy cycles so far.
    int m_owner, m_last, m_cnt;
    int n_owner, n_last, n_cnt;

    logic           e_wait [2];
    logic           e_err  [2];
    logic [31:0]    e_rdata[2];
    logic           e_rd_en, e_wr_en;
    logic [AW-1:0]  e_addr;
    logic [31:0]    e_wdata;
    logic [3:0]     e_strb;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit is_req[2];
        bit is_ok [2];
        int g;
        bit serve;
        for (int i = 0; i < 2; i++) begin
            e_wait[i]  = 1'b0;
            e_err[i]   = 1'b0;
            e_rdata[i] = '0;
        end
        e_rd_en = 1'b0; e_wr_en = 1'b0; e_addr = '0; e_wdata = '0; e_strb = '0;
        n_owner = m_owner; n_last = m_last; n_cnt = m_cnt;
        if (!rst_n) begin
            n_owner = -1; n_last = 1; n_cnt = 0;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            is_req[i] = rd_en[i] || wr_en[i];
            is_ok[i]  = is_req[i] && !(rd_en[i] && wr_en[i]);
            if (rd_en[i] && wr_en[i]) e_err[i] = 1'b1;
            else if (is_ok[i])        e_wait[i] = 1'b1;
        end
        g = -1;
        serve = 1'b0;
        if (m_owner < 0) begin
            if (is_ok[0] && is_ok[1]) g = 1 - m_last;
            else if (is_ok[0])        g = 0;
            else if (is_ok[1])        g = 1;
            serve = (g >= 0);
        end else begin
            g = m_owner;
            if (!is_req[g]) begin
                n_owner = -1; n_cnt = 0;
            end else if (axi_busy && m_cnt == T) begin
                e_wait[g] = 1'b0; e_err[g] = 1'b1;
                n_owner = -1; n_last = g; n_cnt = 0;
            end else begin
                serve = 1'b1;
            end
        end
        if (serve) begin
            e_rd_en = rd_en[g]; e_wr_en = wr_en[g]; e_addr = addr[g];
            e_wdata = wdat[g];  e_strb  = strb[g];
            if (!axi_busy) begin
                e_wait[g] = 1'b0; e_err[g] = axi_access_fault; e_rdata[g] = axi_rd_data;
                n_owner = -1; n_last = g; n_cnt = 0;
            end else begin
                e_wait[g] = 1'b1; n_owner = g; n_cnt = m_cnt + 1;
            end
        end
    endtask

    // Settle combinational outputs, then compare every output to the model.
    task automatic settle();
        #1;
        model_eval();
        chk("axi_rd_en", axi_rd_en, e_rd_en);
        chk("axi_wr_en", axi_wr_en, e_wr_en);
        chk("axi_addr", axi_addr, e_addr);
        chk("axi_wr_data", axi_wr_data, e_wdata);
        chk("axi_wr_strobe", axi_wr_strobe, e_strb);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("r%0d_wait", i), wait_o[i], e_wait[i]);
            chk($sformatf("r%0d_err", i), err_o[i], e_err[i]);
            chk($sformatf("r%0d_rd_data", i), rdat_o[i], e_rdata[i]);
        end
    endtask

    task automatic advance();
        m_owner = n_owner; m_last = n_last; m_cnt = n_cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        rd_en[i] = rd; wr_en[i] = wr; addr[i] = a; wdat[i] = d; strb[i] = s;
    endtask

    task automatic clr_all();
        for (int i = 0; i < 2; i++) set_req(i, 1'b0, 1'b0, '0, '0, '0);
        axi_busy = 1'b0; axi_access_fault = 1'b0; axi_rd_data = '0;
    endtask

    initial begin
        m_owner = -1; m_last = 1; m_cnt = 0;
        clr_all();
        rst_n = 1'b0;

        // Reset: outputs forced low even with a request present.
        set_req(0, 1'b1, 1'b0, 32'h40, '0, '0);
        settle();
        chk("rst_axi_rd_en", axi_rd_en, 1'b0);
        chk("rst_r0_wait", wait_o[0], 1'b0);
        advance();
        advance();

        // Tie straight after reset resolves to r0, then r1.
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h10, '0, '0);
        set_req(1, 1'b1, 1'b0, 32'h20, '0, '0);
        axi_rd_data = 32'h1111_1111;
        settle();
        chk("tie_r0_rd_data", rdat_o[0], 32'h1111_1111);
        chk("tie_r0_wait", wait_o[0], 1'b0);
        chk("tie_r1_wait", wait_o[1], 1'b1);
        chk("tie_axi_addr", axi_addr, 32'h10);
        advance();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        axi_rd_data = 32'h2222_2222;
        settle();
        chk("tie_r1_rd_data", rdat_o[1], 32'h2222_2222);
        chk("tie_r1_wait2", wait_o[1], 1'b0);
        advance();
        clr_all();

        // Single zero-latency read.
        set_req(0, 1'b1, 1'b0, 32'h100, '0, '0);
        axi_rd_data = 32'hDEAD_BEEF;
        settle();
        chk("rd_r0_rd_data", rdat_o[0], 32'hDEAD_BEEF);
        chk("rd_r0_wait", wait_o[0], 1'b0);
        advance();
        clr_all();

        // r1 write stalled by the slave for three cycles.
        set_req(1, 1'b0, 1'b1, 32'h200, 32'h1234_5678, 4'hF);
        for (int c = 1; c <= 4; c++) begin
            axi_busy = (c <= 3);
            settle();
            chk("wr_r1_wait", wait_o[1], logic'(c <= 3));
            chk("wr_axi_wr_en", axi_wr_en, 1'b1);
            chk("wr_axi_data", axi_wr_data, 32'h1234_5678);
            chk("wr_axi_addr", axi_addr, 32'h200);
            advance();
        end
        clr_all();

        // Hung slave: fault on the fifth busy cycle.
        set_req(0, 1'b1, 1'b0, 32'h300, '0, '0);
        axi_busy = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            settle();
            chk("tmo_r0_err", err_o[0], logic'(c == 5));
            chk("tmo_r0_wait", wait_o[0], logic'(c < 5));
            chk("tmo_axi_rd_en", axi_rd_en, logic'(c < 5));
            advance();
        end
        clr_all();
        settle();
        advance();

        // Illegal read+write, then slave-reported fault.
        set_req(0, 1'b1, 1'b1, 32'h44, 32'h55, 4'h3);
        settle();
        chk("ill_r0_err", err_o[0], 1'b1);
        chk("ill_r0_wait", wait_o[0], 1'b0);
        chk("ill_axi_rd_en", axi_rd_en, 1'b0);
        chk("ill_axi_wr_en", axi_wr_en, 1'b0);
        advance();
        set_req(0, 1'b1, 1'b0, 32'h48, '0, '0);
        axi_access_fault = 1'b1;
        settle();
        chk("flt_r0_err", err_o[0], 1'b1);
        chk("flt_r0_wait", wait_o[0], 1'b0);
        advance();
        clr_all();

        // Reset while r1 owns the port; afterwards a tie goes to r0.
        set_req(1, 1'b1, 1'b0, 32'h400, '0, '0);
        axi_busy = 1'b1;
        settle();
        advance();
        rst_n = 1'b0;
        settle();
        chk("rstb_r1_wait", wait_o[1], 1'b0);
        chk("rstb_axi_rd_en", axi_rd_en, 1'b0);
        chk("rstb_r1_err", err_o[1], 1'b0);
        advance();
        rst_n = 1'b1;
        axi_busy = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h500, '0, '0);
        settle();
        chk("rsta_r0_wait", wait_o[0], 1'b0);
        chk("rsta_r1_wait", wait_o[1], 1'b1);
        chk("rsta_axi_addr", axi_addr, 32'h500);
        advance();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        settle();
        advance();
        clr_all();

        // Random traffic honouring the hold-while-wait contract.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < 2; i++) begin
                if (e_wait[i]) begin
                    if (m_owner == i && $urandom_range(0, 19) == 0)
                        set_req(i, 1'b0, 1'b0, '0, '0, '0);
                end else begin
                    int r;
                    r = $urandom_range(0, 9);
                    set_req(i, r inside {[4:6], 9}, r inside {7, 8, 9},
                            $urandom, $urandom, 4'($urandom));
                    if (r < 4) set_req(i, 1'b0, 1'b0, '0, '0, '0);
                end
            end
            axi_busy         = ($urandom_range(0, 9) < 6);
            axi_rd_data      = $urandom;
            axi_access_fault = ($urandom_range(0, 7) == 0);
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
